// File: rtl/tb4004_pkg.sv
// rtl/tb4004_pkg.sv - shared op/state encodings and arbitration defaults
package tb4004_pkg;

    typedef enum logic [1:0] {
        OP_RD4 = 2'b00,
        OP_WR4 = 2'b01,
        OP_RD8 = 2'b10,
        OP_WR8 = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ACC0 = 2'b01,
        ST_ACC1 = 2'b10,
        ST_RESP = 2'b11
    } state_e;

    localparam int STARVE_LIMIT_DEFAULT = 4;

    // Bit 1 of the op selects a register pair, bit 0 selects a write.
    function automatic logic op_is_pair(op_e op);
        return op[1];
    endfunction

    function automatic logic op_is_write(op_e op);
        return op[0];
    endfunction

endpackage

// File: rtl/reg_pair_arbiter_if.sv
// rtl/reg_pair_arbiter_if.sv - requester, response and register-file bus bundle
interface reg_pair_arbiter_if;

    logic       coreReq;
    logic [1:0] coreOp;
    logic [3:0] coreIdx;
    logic [7:0] coreWdata;
    logic       coreAck;

    logic       debugReq;
    logic [1:0] debugOp;
    logic [3:0] debugIdx;
    logic [7:0] debugWdata;
    logic       debugAck;

    logic       respValid;
    logic       respId;
    logic [7:0] respData;
    logic       busy;

    logic       regWe;
    logic [3:0] regAddr;
    logic [3:0] regDin;
    logic [3:0] regDout;

    modport slave (
        input  coreReq, coreOp, coreIdx, coreWdata,
        output coreAck,
        input  debugReq, debugOp, debugIdx, debugWdata,
        output debugAck,
        output respValid, respId, respData, busy,
        output regWe, regAddr, regDin,
        input  regDout
    );

    modport master (
        output coreReq, coreOp, coreIdx, coreWdata,
        input  coreAck,
        output debugReq, debugOp, debugIdx, debugWdata,
        input  debugAck,
        input  respValid, respId, respData, busy,
        input  regWe, regAddr, regDin,
        output regDout
    );

endinterface

// File: rtl/reg_arb_pick.sv
// rtl/reg_arb_pick.sv - core-priority grant selection with debug starvation guard
module reg_arb_pick
    import tb4004_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic coreReq,
    input  logic debugReq,
    input  logic grantEn,
    output logic grantCore,
    output logic grantDebug
);

    localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] starveCnt;
    logic          debugWins;

    always_comb begin
        debugWins  = debugReq && (!coreReq || (starveCnt == LIMIT));
        grantDebug = grantEn && debugWins;
        grantCore  = grantEn && coreReq && !debugWins;
    end

    // Only core grants that leave debug waiting count toward starvation.
    always_ff @(posedge clk) begin
        if (rst) begin
            starveCnt <= '0;
        end else if (grantCore && debugReq) begin
            if (starveCnt != LIMIT) begin
                starveCnt <= starveCnt + 1'b1;
            end
        end else if (grantCore || grantDebug) begin
            starveCnt <= '0;
        end
    end

endmodule

// File: rtl/reg_pair_arbiter.sv
// rtl/reg_pair_arbiter.sv - two-requester nibble/pair register file access sequencer
module reg_pair_arbiter
    import tb4004_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    reg_pair_arbiter_if.slave  bus
);

    state_e     state;
    state_e     stateNext;
    op_e        op;
    logic [3:0] idx;
    logic [7:0] wdata;
    logic       id;
    logic [7:0] rdata;

    logic grantEn;
    logic grantCore;
    logic grantDebug;

    assign grantEn = (state == ST_IDLE) && !rst;

    reg_arb_pick #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_pick (
        .clk        (clk),
        .rst        (rst),
        .coreReq    (bus.coreReq),
        .debugReq   (bus.debugReq),
        .grantEn    (grantEn),
        .grantCore  (grantCore),
        .grantDebug (grantDebug)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            op    <= OP_RD4;
            idx   <= 4'h0;
            wdata <= 8'h00;
            id    <= 1'b0;
            rdata <= 8'h00;
        end else begin
            state <= stateNext;
            if (grantCore) begin
                op    <= op_e'(bus.coreOp);
                idx   <= bus.coreIdx;
                wdata <= bus.coreWdata;
                id    <= 1'b0;
            end else if (grantDebug) begin
                op    <= op_e'(bus.debugOp);
                idx   <= bus.debugIdx;
                wdata <= bus.debugWdata;
                id    <= 1'b1;
            end
            // Even register of a pair is the high nibble, odd is the low nibble.
            if (!op_is_write(op)) begin
                if (state == ST_ACC0) begin
                    if (op_is_pair(op)) begin
                        rdata[7:4] <= bus.regDout;
                    end else begin
                        rdata <= {4'h0, bus.regDout};
                    end
                end else if (state == ST_ACC1) begin
                    rdata[3:0] <= bus.regDout;
                end
            end
        end
    end

    always_comb begin
        stateNext     = state;
        bus.coreAck   = grantCore;
        bus.debugAck  = grantDebug;
        bus.respValid = 1'b0;
        bus.respId    = 1'b0;
        bus.respData  = 8'h00;
        bus.busy      = (state != ST_IDLE);
        bus.regWe     = 1'b0;
        bus.regAddr   = 4'h0;
        bus.regDin    = 4'h0;

        case (state)
            ST_IDLE: begin
                if (grantCore || grantDebug) begin
                    stateNext = ST_ACC0;
                end
            end
            ST_ACC0: begin
                stateNext   = op_is_pair(op) ? ST_ACC1 : ST_RESP;
                bus.regWe   = op_is_write(op);
                bus.regAddr = op_is_pair(op) ? {idx[3:1], 1'b0} : idx;
                if (op_is_write(op)) begin
                    bus.regDin = op_is_pair(op) ? wdata[7:4] : wdata[3:0];
                end
            end
            ST_ACC1: begin
                stateNext   = ST_RESP;
                bus.regWe   = op_is_write(op);
                bus.regAddr = {idx[3:1], 1'b1};
                if (op_is_write(op)) begin
                    bus.regDin = wdata[3:0];
                end
            end
            ST_RESP: begin
                stateNext     = ST_IDLE;
                bus.respValid = 1'b1;
                bus.respId    = id;
                if (!op_is_write(op)) begin
                    bus.respData = op_is_pair(op) ? rdata : {4'h0, rdata[3:0]};
                end
            end
            default: stateNext = ST_IDLE;
        endcase

        // Reset silences everything in the same cycle so an aborted op cannot write.
        if (rst) begin
            bus.coreAck   = 1'b0;
            bus.debugAck  = 1'b0;
            bus.respValid = 1'b0;
            bus.respId    = 1'b0;
            bus.respData  = 8'h00;
            bus.busy      = 1'b0;
            bus.regWe     = 1'b0;
            bus.regAddr   = 4'h0;
            bus.regDin    = 4'h0;
        end
    end

endmodule

// File: tb/tb_reg_pair_arbiter.sv
// tb/tb_reg_pair_arbiter.sv - vector table and scoreboard bench for reg_pair_arbiter
module tb_reg_pair_arbiter;
    import tb4004_pkg::*;

    typedef struct {
        bit         id;
        logic [1:0] op;
        logic [3:0] idx;
        logic [7:0] wdata;
        logic [7:0] exp_data;
        int         lat;
    } vec_t;

    typedef struct {
        bit         id;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    exp_t sb[$];
    exp_t e;
    logic [3:0] regs [16] = '{3: 4'h5, default: 4'h0};

    reg_pair_arbiter_if intf ();

    reg_pair_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (intf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign intf.regDout = regs[intf.regAddr];
    always @(posedge clk) begin
        if (intf.regWe) regs[intf.regAddr] <= intf.regDin;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (intf.respValid) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL resp_unexpected: got respValid id=%0d data=%0h expected none (cycle %0d)",
                         intf.respId, intf.respData, cyc);
            end else begin
                e = sb.pop_front();
                check("resp_id", intf.respId, e.id);
                check("resp_data", intf.respData, e.data);
                check("resp_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic drive(input bit id, input bit req, input logic [1:0] op, input logic [3:0] idx,
                         input logic [7:0] wd);
        if (!id) begin
            intf.coreReq = req; intf.coreOp = op; intf.coreIdx = idx; intf.coreWdata = wd;
        end else begin
            intf.debugReq = req; intf.debugOp = op; intf.debugIdx = idx; intf.debugWdata = wd;
        end
    endtask

    function automatic logic ack_of(input bit id);
        return id ? intf.debugAck : intf.coreAck;
    endfunction

    task automatic do_req(input bit id, input logic [1:0] op, input logic [3:0] idx, input logic [7:0] wd,
                          input logic [7:0] exp_data, input int lat, input bit expect_resp);
        bit got;
        got = 0;
        drive(id, 1'b1, op, idx, wd);
        for (int n = 0; n < 20 && !got; n++) begin
            #1;
            if (ack_of(id)) begin
                got = 1;
                check("other_ack", ack_of(!id), 0);
                if (expect_resp) sb.push_back('{id, exp_data, cyc + lat});
            end
            @(posedge clk); #1;
        end
        drive(id, 1'b0, 2'b00, 4'h0, 8'h00);
        check("ack_seen", got, 1);
    endtask

    task automatic drain();
        for (int n = 0; n < 20; n++) begin
            if (sb.size() == 0 && !intf.busy) break;
            @(posedge clk); #1;
        end
        check("drained", sb.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish within time limit");
        $fatal(1, "watchdog");
    end

    vec_t vecs [10];
    bit   got;
    int   c0;

    initial begin
        vecs[0] = '{1'b0, OP_WR8, 4'd5,  8'hA3, 8'h00, 3};
        vecs[1] = '{1'b0, OP_RD8, 4'd4,  8'h00, 8'hA3, 3};
        vecs[2] = '{1'b1, OP_WR4, 4'd15, 8'h07, 8'h00, 2};
        vecs[3] = '{1'b1, OP_RD4, 4'd15, 8'h00, 8'h07, 2};
        vecs[4] = '{1'b0, OP_WR4, 4'd0,  8'hF9, 8'h00, 2};
        vecs[5] = '{1'b0, OP_RD4, 4'd0,  8'h00, 8'h09, 2};
        vecs[6] = '{1'b1, OP_RD8, 4'd5,  8'h00, 8'hA3, 3};
        vecs[7] = '{1'b0, OP_WR8, 4'd14, 8'h5C, 8'h00, 3};
        vecs[8] = '{1'b1, OP_RD4, 4'd15, 8'h00, 8'h0C, 2};
        vecs[9] = '{1'b0, OP_RD8, 4'd15, 8'h00, 8'h5C, 3};

        // Reset with a pending request: nothing may be granted or written.
        rst = 1'b1;
        drive(1'b1, 1'b0, 2'b00, 4'h0, 8'h00);
        drive(1'b0, 1'b1, OP_WR4, 4'd3, 8'h0E);
        @(posedge clk); #1;
        @(posedge clk); #2;
        check("rst_coreAck", intf.coreAck, 0);
        check("rst_debugAck", intf.debugAck, 0);
        check("rst_busy", intf.busy, 0);
        check("rst_respValid", intf.respValid, 0);
        check("rst_respId", intf.respId, 0);
        check("rst_respData", intf.respData, 0);
        check("rst_regWe", intf.regWe, 0);
        check("rst_regAddr", intf.regAddr, 0);
        check("rst_regDin", intf.regDin, 0);
        drive(1'b0, 1'b0, 2'b00, 4'h0, 8'h00);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("idle_busy", intf.busy, 0);
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            do_req(vecs[i].id, vecs[i].op, vecs[i].idx, vecs[i].wdata, vecs[i].exp_data, vecs[i].lat, 1'b1);
            drain();
        end
        check("reg4", regs[4], 4'hA);
        check("reg5", regs[5], 4'h3);
        check("reg0", regs[0], 4'h9);
        check("reg14", regs[14], 4'h5);
        check("reg15", regs[15], 4'hC);

        // Both requesters held continuously: debug forced every fifth grant.
        drive(1'b0, 1'b1, OP_RD4, 4'd0, 8'h00);
        drive(1'b1, 1'b1, OP_RD4, 4'd15, 8'h00);
        for (int g = 0; g < 10; g++) begin
            got = 0;
            for (int n = 0; n < 12 && !got; n++) begin
                #1;
                if (intf.coreAck || intf.debugAck) begin
                    got = 1;
                    check($sformatf("grant%0d_debug", g), intf.debugAck, (g == 4 || g == 9));
                    check("grant_onehot", intf.coreAck & intf.debugAck, 0);
                    if (g == 4 || g == 9) sb.push_back('{1'b1, 8'h0C, cyc + 2});
                    else                  sb.push_back('{1'b0, 8'h09, cyc + 2});
                end
                @(posedge clk); #1;
            end
            check("grant_seen", got, 1);
        end
        drive(1'b0, 1'b0, 2'b00, 4'h0, 8'h00);
        drive(1'b1, 1'b0, 2'b00, 4'h0, 8'h00);
        drain();

        // Simultaneous first request: core wins, debug waits with fields intact.
        drive(1'b0, 1'b1, OP_RD4, 4'd0, 8'h00);
        drive(1'b1, 1'b1, OP_WR4, 4'd9, 8'h0B);
        #1;
        check("sim_coreAck", intf.coreAck, 1);
        check("sim_debugAck", intf.debugAck, 0);
        c0 = cyc;
        sb.push_back('{1'b0, 8'h09, c0 + 2});
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 2'b00, 4'h0, 8'h00);
        got = 0;
        for (int n = 0; n < 10 && !got; n++) begin
            #1;
            if (intf.debugAck) begin
                got = 1;
                check("sim_debug_ack_cycle", cyc, c0 + 3);
                sb.push_back('{1'b1, 8'h00, cyc + 2});
            end
            @(posedge clk); #1;
        end
        check("sim_debug_ack_seen", got, 1);
        drive(1'b1, 1'b0, 2'b00, 4'h0, 8'h00);
        drain();
        check("reg9", regs[9], 4'hB);

        // Reset in ACC1 of a pair write: even nibble lands, odd is never written.
        do_req(1'b0, OP_WR8, 4'd2, 8'hFF, 8'h00, 3, 1'b0);
        #1;
        check("acc0_regWe", intf.regWe, 1);
        check("acc0_regAddr", intf.regAddr, 4'd2);
        check("acc0_regDin", intf.regDin, 4'hF);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("abort_regWe", intf.regWe, 0);
        check("abort_respValid", intf.respValid, 0);
        check("abort_busy", intf.busy, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("post_busy", intf.busy, 0);
        check("post_regWe", intf.regWe, 0);
        check("post_regAddr", intf.regAddr, 0);
        check("post_respValid", intf.respValid, 0);
        @(posedge clk); #1;
        check("abort_reg2", regs[2], 4'hF);
        check("abort_reg3", regs[3], 4'h5);
        do_req(1'b0, OP_RD8, 4'd2, 8'h00, 8'hF5, 3, 1'b1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
